fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The master side issues requests and consumes in-order responses.
interface fetch_stage_if #(
   parameter int INST_LEN = 32
);
   logic                imem_req_valid_out;
   logic [31:0]         imem_req_addr_out;
   logic                imem_req_ready_in;
   logic                imem_rsp_valid_in;
   logic [INST_LEN-1:0] imem_rsp_data_in;

   modport master (
      output imem_req_valid_out,
      output imem_req_addr_out,
      input  imem_req_ready_in,
      input  imem_rsp_valid_in,
      input  imem_rsp_data_in
   );

   modport slave (
      input  imem_req_valid_out,
      input  imem_req_addr_out,
      output imem_req_ready_in,
      output imem_rsp_valid_in,
      output imem_rsp_data_in
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited imem requests, in-order PC tagging,
// a 2-entry instruction queue to decode, and redirect/flush handling.
module fetch_stage #(
   parameter logic [31:0]         RESET_PC = 32'h0000_0000,
   parameter int                  INST_LEN = 32,
   parameter logic [INST_LEN-1:0] NOP_INST = INST_LEN'(32'h0000_0013)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_dec_in,
   input  logic                branch_taken_in,
   input  logic [31:0]         branch_target_in,
   fetch_stage_if.master       imem,
   output logic [INST_LEN-1:0] inst_fetched_out,
   output logic                inst_valid_out,
   output logic [31:0]         pc_out
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   logic [1:0]          state_r;
   logic [1:0]          state_nxt_s;
   logic [31:0]         fetch_pc_r;
   logic [1:0]          outstanding_r;
   logic [1:0]          outstanding_nxt_s;

   logic [31:0]         tag_pc_r [2];
   logic                tag_rd_r;
   logic                tag_wr_r;

   logic [INST_LEN-1:0] iq_data_r [2];
   logic [31:0]         iq_pc_r [2];
   logic                iq_rd_r;
   logic                iq_wr_r;
   logic [1:0]          iq_cnt_r;

   logic                redirect_s;
   logic                credit_ok_s;
   logic                req_valid_s;
   logic                accept_s;
   logic                rsp_seen_s;
   logic                rsp_keep_s;
   logic                consume_s;

   // Per-cycle event decode; a redirect masks every other queue event.
   always_comb begin
      redirect_s        = rst & branch_taken_in & (state_r != ST_BOOT);
      credit_ok_s       = ({1'b0, outstanding_r} + {1'b0, iq_cnt_r}) < 3'd2;
      req_valid_s       = rst & (state_r == ST_RUN) & ~redirect_s & credit_ok_s;
      accept_s          = req_valid_s & imem.imem_req_ready_in;
      rsp_seen_s        = rst & imem.imem_rsp_valid_in & (outstanding_r != 2'd0)
                          & (state_r != ST_BOOT);
      rsp_keep_s        = rsp_seen_s & (state_r == ST_RUN) & ~redirect_s;
      consume_s         = rst & (iq_cnt_r != 2'd0) & ~stall_dec_in & ~redirect_s;
      outstanding_nxt_s = outstanding_r + {1'b0, accept_s} - {1'b0, rsp_seen_s};
   end

   // Next-state logic; leaving FLUSH waits for every stale response to drain.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_s && (outstanding_nxt_s != 2'd0)) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (outstanding_nxt_s == 2'd0) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   // Control state, fetch PC and outstanding-request counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= ST_BOOT;
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= 2'd0;
      end else begin
         state_r       <= state_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         if (state_r == ST_BOOT) begin
            fetch_pc_r <= RESET_PC;
         end else if (redirect_s) begin
            fetch_pc_r <= align_word(branch_target_in);
         end else if (accept_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
         end else begin
            fetch_pc_r <= fetch_pc_r;
         end
      end
   end

   // PC tag queue; tags of requests in flight at a redirect are discarded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_pc_r[0] <= 32'd0;
         tag_pc_r[1] <= 32'd0;
         tag_rd_r    <= 1'b0;
         tag_wr_r    <= 1'b0;
      end else if (redirect_s) begin
         tag_rd_r <= 1'b0;
         tag_wr_r <= 1'b0;
      end else begin
         if (accept_s) begin
            tag_pc_r[tag_wr_r] <= fetch_pc_r;
            tag_wr_r           <= ~tag_wr_r;
         end
         if (rsp_keep_s) begin
            tag_rd_r <= ~tag_rd_r;
         end
      end
   end

   // Instruction queue feeding decode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         iq_data_r[0] <= NOP_INST;
         iq_data_r[1] <= NOP_INST;
         iq_pc_r[0]   <= 32'd0;
         iq_pc_r[1]   <= 32'd0;
         iq_rd_r      <= 1'b0;
         iq_wr_r      <= 1'b0;
         iq_cnt_r     <= 2'd0;
      end else if (redirect_s) begin
         iq_rd_r  <= 1'b0;
         iq_wr_r  <= 1'b0;
         iq_cnt_r <= 2'd0;
      end else begin
         if (rsp_keep_s) begin
            iq_data_r[iq_wr_r] <= imem.imem_rsp_data_in;
            iq_pc_r[iq_wr_r]   <= tag_pc_r[tag_rd_r];
            iq_wr_r            <= ~iq_wr_r;
         end
         if (consume_s) begin
            iq_rd_r <= ~iq_rd_r;
         end
         iq_cnt_r <= iq_cnt_r + {1'b0, rsp_keep_s} - {1'b0, consume_s};
      end
   end

   // Output drive; the queue head is presented combinationally.
   always_comb begin
      imem.imem_req_valid_out = req_valid_s;
      imem.imem_req_addr_out  = fetch_pc_r;
      inst_valid_out          = rst & (iq_cnt_r != 2'd0);
      if (inst_valid_out) begin
         inst_fetched_out = iq_data_r[iq_rd_r];
         pc_out           = iq_pc_r[iq_rd_r];
      end else begin
         inst_fetched_out = NOP_INST;
         pc_out           = 32'd0;
      end
   end

endmodule
